// File: rtl/tqvp_quad_encoder_bank.sv
// Multi-channel quadrature encoder bank for the TinyQV peripheral bus.
// Each A/B pair is debounced on a shared prescaler strobe, decoded, and counted.
module tqvp_quad_encoder_bank #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16,
    parameter int HIST_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);
    localparam int NIN = 2 * NUM_CH;

    logic [7:0]                        r_deb_cmp;
    logic [7:0]                        r_presc;
    logic [7:0]                        r_mode;
    logic [NUM_CH-1:0]                 r_status;
    logic [NUM_CH-1:0]                 r_dir;
    logic [NIN-1:0][HIST_LEN-1:0]      r_hist;
    logic [NIN-1:0]                    r_deb;
    logic [NUM_CH-1:0][1:0]            r_prev;
    logic [NUM_CH-1:0][CNT_W-1:0]      r_cnt;
    logic [NUM_CH-1:0][CNT_W-1:0]      r_snap;

    logic                              w_strobe;
    logic                              w_wr_deb;
    logic                              w_wr_mode;
    logic                              w_wr_stat;
    logic                              w_wr_cmd;
    logic                              w_snap_now;
    logic [NIN-1:0][HIST_LEN-1:0]      w_hist_next;
    logic [NUM_CH-1:0]                 w_up;
    logic [NUM_CH-1:0]                 w_dn;
    logic [NUM_CH-1:0]                 w_clr;
    logic [NUM_CH-1:0]                 w_wrap;
    logic [NUM_CH-1:0]                 w_w1c;
    logic [7:0]                        w_stat_ext;
    logic [NUM_CH-1:0][15:0]           w_snap_ext;

    assign w_strobe   = (r_presc == r_deb_cmp);
    assign w_wr_deb   = data_write && (address == 4'h0);
    assign w_wr_mode  = data_write && (address == 4'h1);
    assign w_wr_stat  = data_write && (address == 4'h2);
    assign w_wr_cmd   = data_write && (address == 4'h3);
    assign w_snap_now = w_wr_cmd && data_in[7];
    assign w_w1c      = w_wr_stat ? data_in[NUM_CH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= 8'h00;
        end else if (w_wr_deb || w_strobe) begin
            r_presc <= 8'h00;
        end else begin
            r_presc <= r_presc + 8'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < NIN; i++) begin
            w_hist_next[i] = {r_hist[i][HIST_LEN-2:0], ui_in[i]};
        end
    end

    // Output only moves on a unanimous history; mixed histories hold the last level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hist <= '0;
            r_deb  <= '0;
        end else if (w_strobe) begin
            for (int i = 0; i < NIN; i++) begin
                r_hist[i] <= w_hist_next[i];
                if (w_hist_next[i] == '1) begin
                    r_deb[i] <= 1'b1;
                end else if (w_hist_next[i] == '0) begin
                    r_deb[i] <= 1'b0;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_dec
            logic       w_a, w_b, w_pa, w_pb;
            logic [1:0] w_ph, w_pph, w_dph;
            logic       w_ev, w_raw_up, w_dir;

            assign w_a  = r_deb[2*gi];
            assign w_b  = r_deb[2*gi+1];
            assign w_pa = r_prev[gi][1];
            assign w_pb = r_prev[gi][0];
            // Gray position 00,10,11,01 -> 0..3; an odd step is one valid edge.
            assign w_ph  = {w_b, w_a ^ w_b};
            assign w_pph = {w_pb, w_pa ^ w_pb};
            assign w_dph = w_ph - w_pph;

            always_comb begin
                w_ev     = 1'b0;
                w_raw_up = 1'b0;
                case (r_mode[1:0])
                    2'd1: begin
                        w_ev     = w_a ^ w_pa;
                        w_raw_up = w_a ^ w_b;
                    end
                    2'd2: begin
                        w_ev     = w_a & ~w_pa;
                        w_raw_up = ~w_b;
                    end
                    default: begin
                        w_ev     = w_dph[0];
                        w_raw_up = (w_dph == 2'd1);
                    end
                endcase
            end

            assign w_dir    = w_raw_up ^ r_mode[4+gi];
            assign w_up[gi] = w_ev & w_dir;
            assign w_dn[gi] = w_ev & ~w_dir;
        end
    endgenerate

    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            w_clr[n]  = w_wr_cmd & data_in[n];
            w_wrap[n] = ~w_clr[n] & ((w_up[n] & (r_cnt[n] == '1)) |
                                     (w_dn[n] & (r_cnt[n] == '0)));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_deb_cmp <= 8'd64;
            r_mode    <= 8'h00;
            r_status  <= '0;
            r_dir     <= '0;
            r_prev    <= '0;
            r_cnt     <= '0;
            r_snap    <= '0;
        end else begin
            if (w_wr_deb) begin
                r_deb_cmp <= data_in;
            end
            if (w_wr_mode) begin
                r_mode <= {data_in[7:4], 2'b00, data_in[1:0]};
            end
            // A wrap in the same cycle as its W1C keeps the flag set.
            r_status <= (r_status & ~w_w1c) | w_wrap;
            for (int n = 0; n < NUM_CH; n++) begin
                r_prev[n] <= {r_deb[2*n], r_deb[2*n+1]};
                if (w_snap_now) begin
                    r_snap[n] <= r_cnt[n];
                end
                if (w_clr[n]) begin
                    r_cnt[n] <= '0;
                end else if (w_up[n]) begin
                    r_cnt[n] <= r_cnt[n] + CNT_W'(1);
                    r_dir[n] <= 1'b1;
                end else if (w_dn[n]) begin
                    r_cnt[n] <= r_cnt[n] - CNT_W'(1);
                    r_dir[n] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        uo_out              = 8'h00;
        uo_out[NUM_CH-1:0]  = r_dir;
    end

    always_comb begin
        data_out                  = 8'h00;
        w_stat_ext                = 8'h00;
        w_stat_ext[NUM_CH-1:0]    = r_status;
        w_snap_ext                = '0;
        case (address)
            4'h0:    data_out = r_deb_cmp;
            4'h1:    data_out = r_mode;
            4'h2:    data_out = w_stat_ext;
            default: data_out = 8'h00;
        endcase
        for (int n = 0; n < NUM_CH; n++) begin
            w_snap_ext[n][CNT_W-1:0] = r_snap[n];
            if (address == 4'(4 + 2*n)) begin
                data_out = w_snap_ext[n][7:0];
            end
            if (address == 4'(5 + 2*n)) begin
                data_out = w_snap_ext[n][15:8];
            end
        end
    end
endmodule

// File: tb/tb_tqvp_quad_encoder_bank.sv
// Bench for tqvp_quad_encoder_bank: directed corner cases plus a random walk
// checked against a step-level model of the encoder bank.
module tb_tqvp_quad_encoder_bank;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uo_out;
    logic [3:0] address = 4'h0;
    logic       data_write = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;

    tqvp_quad_encoder_bank dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ui_in      (ui_in),
        .uo_out     (uo_out),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model state: counts, snapshots, last stable A/B pair ({A,B}), flags, direction, mode.
    int         m_cnt [4];
    int         m_snap[4];
    logic [1:0] m_pair[4];
    logic [3:0] m_stat = 4'h0;
    logic [3:0] m_dir = 4'h0;
    logic [7:0] m_mode = 8'h00;
    logic [1:0] upseq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    int         exp_res [3] = '{8, 4, 2};
    logic [7:0] lo, hi, sv;

    function automatic int ref_step(logic [7:0] mode, int ch, logic [1:0] p, logic [1:0] c);
        int v = 0;
        int ip = 0;
        int ic = 0;
        case (mode[1:0])
            2'd1: if (p[1] != c[1]) v = (c[1] != c[0]) ? 1 : -1;
            2'd2: if (!p[1] && c[1]) v = (c[0] == 1'b0) ? 1 : -1;
            default: begin
                for (int k = 0; k < 4; k++) begin
                    if (upseq[k] == p) ip = k;
                    if (upseq[k] == c) ic = k;
                end
                if ((ip + 1) % 4 == ic) v = 1;
                else if ((ic + 1) % 4 == ip) v = -1;
            end
        endcase
        if (mode[4+ch]) v = -v;
        return v;
    endfunction

    task automatic m_apply(input int ch, input int v);
        if (v > 0) begin
            if (m_cnt[ch] == 65535) m_stat[ch] = 1'b1;
            m_cnt[ch] = (m_cnt[ch] + 1) % 65536;
            m_dir[ch] = 1'b1;
        end else if (v < 0) begin
            if (m_cnt[ch] == 0) m_stat[ch] = 1'b1;
            m_cnt[ch] = (m_cnt[ch] + 65535) % 65536;
            m_dir[ch] = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_pair(input int ch, input logic [1:0] pr);
        ui_in[2*ch]   = pr[1];
        ui_in[2*ch+1] = pr[0];
    endtask

    task automatic step(input int ch, input logic [1:0] pr, input int hold);
        int v;
        v = ref_step(m_mode, ch, m_pair[ch], pr);
        @(negedge clk);
        drive_pair(ch, pr);
        repeat (hold) @(negedge clk);
        m_apply(ch, v);
        m_pair[ch] = pr;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        address    = a;
        data_in    = d;
        data_write = 1'b1;
        @(negedge clk);
        data_write = 1'b0;
        if (a == 4'h1) m_mode = {d[7:4], 2'b00, d[1:0]};
        if (a == 4'h2) m_stat = m_stat & ~d[3:0];
        if (a == 4'h3) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (d[7]) m_snap[ch] = m_cnt[ch];
                if (d[ch]) m_cnt[ch] = 0;
            end
        end
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        address = a;
        #1;
        d = data_out;
    endtask

    task automatic check_all(input string tag);
        wr(4'h3, 8'h80);
        for (int ch = 0; ch < 4; ch++) begin
            rd(4'(4 + 2*ch), lo);
            rd(4'(5 + 2*ch), hi);
            chk($sformatf("%s_snap%0d", tag, ch), {hi, lo}, 16'(m_snap[ch]));
        end
        rd(4'h2, sv);
        chk({tag, "_status"}, {8'h00, sv}, {12'h000, m_stat});
        rd(4'h1, sv);
        chk({tag, "_mode"}, {8'h00, sv}, {8'h00, m_mode});
        chk({tag, "_uo_out"}, {8'h00, uo_out}, {12'h000, m_dir});
    endtask

    initial begin
        for (int ch = 0; ch < 4; ch++) begin
            m_cnt[ch]  = 0;
            m_snap[ch] = 0;
            m_pair[ch] = 2'b00;
        end

        // Reset with inputs held high.
        ui_in = 8'hFF;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        rd(4'h0, sv); chk("rst_deb_cmp", {8'h00, sv}, 16'd64);
        rd(4'h1, sv); chk("rst_mode", {8'h00, sv}, 16'h0000);
        for (int a = 2; a < 16; a++) begin
            rd(4'(a), sv);
            chk($sformatf("rst_addr%0d", a), {8'h00, sv}, 16'h0000);
        end
        chk("rst_uo_out", {8'h00, uo_out}, 16'h0000);
        repeat (300) @(negedge clk);
        for (int ch = 0; ch < 4; ch++) begin
            m_apply(ch, ref_step(m_mode, ch, m_pair[ch], 2'b11));
            m_pair[ch] = 2'b11;
        end
        check_all("rst_hi");

        wr(4'h0, 8'h00);
        for (int ch = 0; ch < 4; ch++) step(ch, 2'b00, 7);

        // x4 up 12 edges then down 5 on channel 1.
        for (int i = 0; i < 12; i++) step(1, upseq[(i + 1) % 4], 7);
        check_all("x4_up");
        rd(4'h6, lo); rd(4'h7, hi);
        chk("snap1_12", {hi, lo}, 16'd12);
        for (int i = 1; i <= 5; i++) step(1, upseq[(12 - i) % 4], 7);
        check_all("x4_down");
        rd(4'h6, lo); rd(4'h7, hi);
        chk("snap1_7", {hi, lo}, 16'd7);
        chk("uo1_down", {15'h0000, uo_out[1]}, 16'h0000);

        // Resolution modes on channel 0.
        for (int r = 0; r < 3; r++) begin
            wr(4'h1, 8'(r));
            wr(4'h3, 8'h01);
            for (int i = 0; i < 8; i++) step(0, upseq[(i + 1) % 4], 7);
            check_all($sformatf("res%0d", r));
            rd(4'h4, lo); rd(4'h5, hi);
            chk($sformatf("res%0d_count", r), {hi, lo}, 16'(exp_res[r]));
        end
        wr(4'h1, 8'h10);
        wr(4'h3, 8'h01);
        for (int i = 0; i < 8; i++) step(0, upseq[(i + 1) % 4], 7);
        check_all("inv");
        rd(4'h4, lo); rd(4'h5, hi);
        chk("inv_count", {hi, lo}, 16'hFFF8);
        wr(4'h2, 8'h01);
        rd(4'h2, sv); chk("w1c_clear", {8'h00, sv}, 16'h0000);

        // Wrap from 0 by one down step.
        wr(4'h1, 8'h00);
        wr(4'h3, 8'h01);
        step(0, 2'b01, 7);
        check_all("wrap");
        rd(4'h4, lo); rd(4'h5, hi);
        chk("wrap_snap", {hi, lo}, 16'hFFFF);
        rd(4'h2, sv); chk("wrap_status", {8'h00, sv}, 16'h0001);
        wr(4'h2, 8'h01);
        rd(4'h2, sv); chk("wrap_w1c", {8'h00, sv}, 16'h0000);

        // W1C landing on the same edge as a new wrap.
        wr(4'h3, 8'h01);
        @(negedge clk);
        drive_pair(0, 2'b11);
        repeat (4) @(negedge clk);
        address = 4'h2; data_in = 8'h01; data_write = 1'b1;
        @(negedge clk);
        data_write = 1'b0;
        repeat (3) @(negedge clk);
        m_cnt[0] = 65535; m_stat[0] = 1'b1; m_dir[0] = 1'b0; m_pair[0] = 2'b11;
        rd(4'h2, sv); chk("w1c_vs_wrap", {8'h00, sv}, 16'h0001);
        check_all("w1c_vs_wrap");
        wr(4'h2, 8'h0F);

        // Snapshot+clear, then a count event in the clear cycle.
        wr(4'h3, 8'h04);
        for (int i = 0; i < 291; i++) step(2, upseq[(i + 1) % 4], 6);
        wr(4'h3, 8'h84);
        rd(4'h8, sv); chk("snapclr_lo", {8'h00, sv}, 16'h0023);
        rd(4'h9, sv); chk("snapclr_hi", {8'h00, sv}, 16'h0001);
        wr(4'h3, 8'h80);
        rd(4'h8, sv); chk("resnap_lo", {8'h00, sv}, 16'h0000);
        rd(4'h9, sv); chk("resnap_hi", {8'h00, sv}, 16'h0000);
        @(negedge clk);
        drive_pair(2, 2'b00);
        repeat (4) @(negedge clk);
        address = 4'h3; data_in = 8'h04; data_write = 1'b1;
        @(negedge clk);
        data_write = 1'b0;
        repeat (3) @(negedge clk);
        m_pair[2] = 2'b00;
        check_all("clr_vs_count");

        // Debounce with DEB_CMP=3 on channel 3.
        wr(4'h0, 8'h03);
        @(negedge clk);
        ui_in[6] = 1'b1;
        repeat (10) @(negedge clk);
        ui_in[6] = 1'b0;
        repeat (40) @(negedge clk);
        check_all("glitch");
        step(3, 2'b10, 16);
        repeat (8) @(negedge clk);
        check_all("stable16");
        rd(4'hA, lo); rd(4'hB, hi);
        chk("stable16_count", {hi, lo}, 16'd1);
        for (int k = 0; k < 4; k++) begin
            ui_in[7] = 1'b1;
            repeat (5) @(negedge clk);
            ui_in[7] = 1'b0;
            repeat (5) @(negedge clk);
        end
        step(3, 2'b11, 40);
        check_all("bounce");
        rd(4'hA, lo); rd(4'hB, hi);
        chk("bounce_count", {hi, lo}, 16'd2);
        wr(4'h0, 8'h00);

        // Random walk against the model.
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 5) == 0) wr(4'h1, 8'($urandom));
            if ($urandom_range(0, 7) == 0) wr(4'h2, 8'($urandom_range(0, 15)));
            if ($urandom_range(0, 9) == 0) wr(4'h3, 8'($urandom_range(1, 15)));
            step($urandom_range(0, 3), 2'($urandom_range(0, 3)), 7);
            if (it % 6 == 5) check_all($sformatf("rand%0d", it));
        end
        check_all("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
